// File: rtl/trap_ctrl_if.sv
// Trap unit bus: execute-stage request inputs and CSR-facing trap/MRET/flush outputs.
interface trap_ctrl_if;
  logic        ext_irq_raw;
  logic        irq_enable;
  logic [1:0]  current_privilege;
  logic        instr_valid;
  logic [31:0] current_pc;
  logic        exc_instr_misaligned;
  logic        exc_illegal;
  logic        exc_ebreak;
  logic        exc_ecall;
  logic        exc_load_misaligned;
  logic        exc_store_misaligned;
  logic        is_mret;
  logic        ext_irq_pending;
  logic        is_trap;
  logic [31:0] trap_cause;
  logic [31:0] trap_instr_pc;
  logic        mret_pulse;
  logic        flush;
  logic        busy;

  modport master (
    output ext_irq_raw, irq_enable, current_privilege, instr_valid, current_pc,
           exc_instr_misaligned, exc_illegal, exc_ebreak, exc_ecall,
           exc_load_misaligned, exc_store_misaligned, is_mret,
    input  ext_irq_pending, is_trap, trap_cause, trap_instr_pc, mret_pulse, flush, busy
  );

  modport slave (
    input  ext_irq_raw, irq_enable, current_privilege, instr_valid, current_pc,
           exc_instr_misaligned, exc_illegal, exc_ebreak, exc_ecall,
           exc_load_misaligned, exc_store_misaligned, is_mret,
    output ext_irq_pending, is_trap, trap_cause, trap_instr_pc, mret_pulse, flush, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// Trap/interrupt request unit: synchronises the external IRQ, prioritises exceptions,
// issues one-cycle trap/MRET requests and sequences the following pipeline flush.
module trap_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  trap_ctrl_if.slave  bus
);
  localparam int CW = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRAP  = 2'd1;
  localparam logic [1:0] MRET  = 2'd2;
  localparam logic [1:0] FLUSH = 2'd3;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   is_trap_q, mret_q;
  logic [31:0]            cause_q, cause_d, pc_q, pc_d;
  logic                   irq_pend, take_trap, take_mret;

  assign irq_pend = sync_q[SYNC_STAGES-1];

  // Requests are only sampled in IDLE; anything raised while busy is dropped.
  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    cause_d   = cause_q;
    pc_d      = pc_q;
    if (state_q == IDLE && bus.instr_valid) begin
      take_trap = 1'b1;
      if (bus.irq_enable && irq_pend)    cause_d = 32'h8000_000B;
      else if (bus.exc_instr_misaligned) cause_d = 32'd0;
      else if (bus.exc_illegal)          cause_d = 32'd2;
      else if (bus.exc_ebreak)           cause_d = 32'd3;
      else if (bus.exc_ecall)            cause_d = (bus.current_privilege == 2'b11) ? 32'd11 : 32'd8;
      else if (bus.exc_load_misaligned)  cause_d = 32'd4;
      else if (bus.exc_store_misaligned) cause_d = 32'd6;
      else begin
        take_trap = 1'b0;
        take_mret = bus.is_mret;
      end
      if (take_trap) pc_d = bus.current_pc;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (take_trap)      state_d = TRAP;
        else if (take_mret) state_d = MRET;
      end
      TRAP, MRET: begin
        cnt_d   = CW'(FLUSH_CYCLES - 1);
        state_d = FLUSH;
      end
      default: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_trap_q <= 1'b0;
      mret_q    <= 1'b0;
      cause_q   <= '0;
      pc_q      <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.ext_irq_raw};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_trap_q <= take_trap;
      mret_q    <= take_mret;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
    end
  end

  assign bus.ext_irq_pending = irq_pend;
  assign bus.is_trap         = is_trap_q;
  assign bus.mret_pulse      = mret_q;
  assign bus.trap_cause      = cause_q;
  assign bus.trap_instr_pc   = pc_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.flush           = (state_q != IDLE);
endmodule
